// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: decoded ID-stage control and pipeline events in,
// stall/flush/forward controls and status out.
// Signalling: there is no valid/ready handshake; every field is sampled on each
// rising clk edge, id_valid=0 marks a bubble in ID (its other ID fields are
// then ignored), and all controller outputs are valid for the whole cycle.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       id_rd;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             id_mem_write;
    logic             ex_redirect;
    logic             dmem_ready;

    logic             pc_stall;
    logic             if_id_stall;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             ex_mem_stall;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Debug view: FSM state and the WB-stage shadow destination.
    logic [1:0]       dbg_state;
    logic [4:0]       dbg_wb_rd;
    logic             dbg_wb_reg_write;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_reg_write, id_mem_read, id_mem_write, ex_redirect, dmem_ready,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_stall,
               fwd_a, fwd_b, mem_err, stall_cnt, flush_cnt,
               dbg_state, dbg_wb_rd, dbg_wb_reg_write
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_reg_write, id_mem_read, id_mem_write, ex_redirect, dmem_ready,
        output pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_stall,
               fwd_a, fwd_b, mem_err, stall_cnt, flush_cnt,
               dbg_state, dbg_wb_rd, dbg_wb_reg_write
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline scheduler for the 5-stage RV32I core. Shadows EX/MEM/WB destinations,
// raises load-use interlock, EX-redirect flush and dmem-wait freeze, selects
// registered forwarding for EX operands and keeps saturating stall/flush counts.
module hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input logic          clk,
    input logic          reset,
    hazard_ctrl_if.slave hz
);
    localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_MEMWAIT = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    // Shadow pipeline of destination/control bits.
    logic [4:0]        ex_rd;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_rw;
    logic [4:0]        mem_rd;
    logic              mem_reg_write;
    logic              mem_mem_rw;
    logic [4:0]        wb_rd;
    logic              wb_reg_write;

    logic              ex_hit_a;
    logic              ex_hit_b;
    logic              mem_hit_a;
    logic              mem_hit_b;
    logic              load_use;
    logic              mem_busy;

    logic              pc_stall;
    logic              if_id_stall;
    logic              if_id_flush;
    logic              id_ex_bubble;
    logic              ex_mem_stall;

    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_err;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    // Operand matches against EX/MEM shadows; x0 never matches.
    always_comb begin
        ex_hit_a  = hz.id_use_rs1 && (hz.id_rs1 != 5'd0) && (hz.id_rs1 == ex_rd)  && ex_reg_write;
        ex_hit_b  = hz.id_use_rs2 && (hz.id_rs2 != 5'd0) && (hz.id_rs2 == ex_rd)  && ex_reg_write;
        mem_hit_a = hz.id_use_rs1 && (hz.id_rs1 != 5'd0) && (hz.id_rs1 == mem_rd) && mem_reg_write;
        mem_hit_b = hz.id_use_rs2 && (hz.id_rs2 != 5'd0) && (hz.id_rs2 == mem_rd) && mem_reg_write;
        load_use  = hz.id_valid && ex_mem_read && (ex_hit_a || ex_hit_b);
        // In MEMWAIT the MEM shadow is frozen on the access, so this is just !dmem_ready there.
        mem_busy  = mem_mem_rw && !hz.dmem_ready;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_RUN;
        else       state <= state_nxt;
    end

    // Next state: dmem freeze beats redirect, redirect beats load-use.
    always_comb begin
        state_nxt = ST_RUN;
        if (mem_busy)            state_nxt = ST_MEMWAIT;
        else if (hz.ex_redirect) state_nxt = ST_RUN;
        else if (load_use)       state_nxt = ST_LDSTALL;
    end

    // Control outputs; every state applies the same priority, and a MEMWAIT exit
    // cycle (dmem_ready=1) falls straight through to redirect/load-use handling.
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_stall = 1'b0;
        if (!reset) begin
            if (mem_busy) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                ex_mem_stall = 1'b1;
            end else if (hz.ex_redirect) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (load_use) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_bubble = 1'b1;
            end
        end
    end

    // Shadow pipeline advance; frozen whole while EX/MEM is held.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_rd         <= 5'd0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_rw     <= 1'b0;
            mem_rd        <= 5'd0;
            mem_reg_write <= 1'b0;
            mem_mem_rw    <= 1'b0;
            wb_rd         <= 5'd0;
            wb_reg_write  <= 1'b0;
        end else if (!ex_mem_stall) begin
            if (id_ex_bubble || !hz.id_valid) begin
                ex_rd        <= 5'd0;
                ex_reg_write <= 1'b0;
                ex_mem_read  <= 1'b0;
                ex_mem_rw    <= 1'b0;
            end else begin
                ex_rd        <= hz.id_rd;
                ex_reg_write <= hz.id_reg_write;
                ex_mem_read  <= hz.id_mem_read;
                ex_mem_rw    <= hz.id_mem_read || hz.id_mem_write;
            end
            mem_rd        <= ex_rd;
            mem_reg_write <= ex_reg_write;
            mem_mem_rw    <= ex_mem_rw;
            wb_rd         <= mem_rd;
            wb_reg_write  <= mem_reg_write;
        end
    end

    // Forward selects follow the instruction into EX: EX-shadow (next MEM) wins over MEM-shadow.
    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_a <= 2'd0;
            fwd_b <= 2'd0;
        end else if (!ex_mem_stall) begin
            if (id_ex_bubble || !hz.id_valid) begin
                fwd_a <= 2'd0;
                fwd_b <= 2'd0;
            end else if (!if_id_stall) begin
                fwd_a <= ex_hit_a ? 2'd1 : (mem_hit_a ? 2'd2 : 2'd0);
                fwd_b <= ex_hit_b ? 2'd1 : (mem_hit_b ? 2'd2 : 2'd0);
            end
        end
    end

    // Dmem wait timer: counts every frozen cycle of one access, sticky error past the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else if (mem_busy) begin
            if (wait_cnt == WAIT_MAX) mem_err  <= 1'b1;
            else                      wait_cnt <= wait_cnt + WAIT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (pc_stall && (stall_cnt != '1))    stall_cnt <= stall_cnt + CNT_W'(1);
            if (if_id_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign hz.pc_stall         = pc_stall;
    assign hz.if_id_stall      = if_id_stall;
    assign hz.if_id_flush      = if_id_flush;
    assign hz.id_ex_bubble     = id_ex_bubble;
    assign hz.ex_mem_stall     = ex_mem_stall;
    assign hz.fwd_a            = fwd_a;
    assign hz.fwd_b            = fwd_b;
    assign hz.mem_err          = mem_err;
    assign hz.stall_cnt        = stall_cnt;
    assign hz.flush_cnt        = flush_cnt;
    assign hz.dbg_state        = state;
    assign hz.dbg_wb_rd        = wb_rd;
    assign hz.dbg_wb_reg_write = wb_reg_write;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a driver issues one ID instruction per cycle
// and queues the hand-computed outputs for that cycle; a monitor compares them.
module tb_hazard_ctrl;
    localparam int CNT_W = 16;
    localparam int EW    = 5 + 2 + 2 + 1 + 2 * CNT_W;

    // ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_stall}
    localparam logic [4:0] C_NONE   = 5'b00000;
    localparam logic [4:0] C_LDUSE  = 5'b11010;
    localparam logic [4:0] C_FLUSH  = 5'b00110;
    localparam logic [4:0] C_FREEZE = 5'b11001;

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic       mw;
    } insn_t;

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();
    hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(64)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    // scoreboard
    logic [EW-1:0] exp_q[$];
    string         name_q[$];
    int            total = 0;
    int            bad   = 0;
    int            e_sc  = 0;
    int            e_fc  = 0;

    function automatic insn_t f_nop();
        insn_t i;
        i = '0;
        return i;
    endfunction

    function automatic insn_t f_lw(input logic [4:0] rd, input logic [4:0] rs1);
        insn_t i;
        i = '0; i.v = 1'b1; i.rs1 = rs1; i.u1 = 1'b1; i.rd = rd; i.rw = 1'b1; i.mr = 1'b1;
        return i;
    endfunction

    function automatic insn_t f_alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        insn_t i;
        i = '0; i.v = 1'b1; i.rs1 = rs1; i.rs2 = rs2; i.u1 = 1'b1; i.u2 = 1'b1; i.rd = rd; i.rw = 1'b1;
        return i;
    endfunction

    // rd field carries immediate bits for a store; reg_write stays low.
    function automatic insn_t f_sw(input logic [4:0] rs1, input logic [4:0] rs2);
        insn_t i;
        i = '0; i.v = 1'b1; i.rs1 = rs1; i.rs2 = rs2; i.u1 = 1'b1; i.u2 = 1'b1; i.rd = 5'd3; i.mw = 1'b1;
        return i;
    endfunction

    task automatic drive(input insn_t ins, input logic redir, input logic dready);
        hz.id_valid     = ins.v;
        hz.id_rs1       = ins.rs1;
        hz.id_rs2       = ins.rs2;
        hz.id_use_rs1   = ins.u1;
        hz.id_use_rs2   = ins.u2;
        hz.id_rd        = ins.rd;
        hz.id_reg_write = ins.rw;
        hz.id_mem_read  = ins.mr;
        hz.id_mem_write = ins.mw;
        hz.ex_redirect  = redir;
        hz.dmem_ready   = dready;
    endtask

    // Drive one cycle (called at posedge+1) and queue that cycle's expected outputs.
    task automatic step(input insn_t ins, input logic redir, input logic dready, input string nm,
                        input logic [4:0] ctl, input logic [1:0] fa, input logic [1:0] fb, input logic err);
        drive(ins, redir, dready);
        exp_q.push_back({ctl, fa, fb, err, CNT_W'(e_sc), CNT_W'(e_fc)});
        name_q.push_back(nm);
        e_sc += int'(ctl[4]);
        e_fc += int'(ctl[2]);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic dready);
        reset = 1'b1;
        drive(f_nop(), 1'b0, dready);
        @(posedge clk);
        #1;
        reset = 1'b0;
        e_sc = 0;
        e_fc = 0;
    endtask

    // monitor
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [EW-1:0] e;
            logic [EW-1:0] a;
            string         n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = {hz.pc_stall, hz.if_id_stall, hz.if_id_flush, hz.id_ex_bubble, hz.ex_mem_stall,
                 hz.fwd_a, hz.fwd_b, hz.mem_err, hz.stall_cnt, hz.flush_cnt};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL %s: got=%h exp=%h (ctl5,fa,fb,err,stall_cnt,flush_cnt)", n, a, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drive(f_nop(), 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        step(f_nop(), 0, 1, "reset_state", C_NONE, 2'd0, 2'd0, 0);

        // lw x5 ; add x6,x5,x1 -> one interlock cycle then fwd_a=2
        step(f_lw(5, 1),      0, 1, "lw_issue",       C_NONE,  2'd0, 2'd0, 0);
        step(f_alu(6, 5, 1),  0, 1, "ld_use_stall",   C_LDUSE, 2'd0, 2'd0, 0);
        step(f_alu(6, 5, 1),  0, 1, "ld_use_release", C_NONE,  2'd0, 2'd0, 0);
        step(f_nop(),         0, 1, "ld_use_fwd2",    C_NONE,  2'd2, 2'd0, 0);

        // add x5 ; sub x7,x5,x5 -> fwd 1/1
        step(f_alu(5, 1, 2),  0, 1, "alu_prod",       C_NONE,  2'd0, 2'd0, 0);
        step(f_alu(7, 5, 5),  0, 1, "alu_cons",       C_NONE,  2'd0, 2'd0, 0);
        step(f_nop(),         0, 1, "fwd_ex_11",      C_NONE,  2'd1, 2'd1, 0);
        // add x5 ; add x9 ; sub x7,x5,x5 -> fwd 2/2
        step(f_alu(5, 1, 2),  0, 1, "alu_prod2",      C_NONE,  2'd0, 2'd0, 0);
        step(f_alu(9, 1, 2),  0, 1, "alu_unrel",      C_NONE,  2'd0, 2'd0, 0);
        step(f_alu(7, 5, 5),  0, 1, "alu_cons2",      C_NONE,  2'd0, 2'd0, 0);
        step(f_nop(),         0, 1, "fwd_mem_22",     C_NONE,  2'd2, 2'd2, 0);

        // lw x0 ; add x6,x0,x0 -> nothing
        step(f_lw(0, 1),      0, 1, "lw_x0",          C_NONE,  2'd0, 2'd0, 0);
        step(f_alu(6, 0, 0),  0, 1, "x0_no_stall",    C_NONE,  2'd0, 2'd0, 0);
        step(f_nop(),         0, 1, "x0_no_fwd",      C_NONE,  2'd0, 2'd0, 0);

        // redirect on the load-use cycle -> flush+bubble only
        step(f_lw(5, 1),      0, 1, "lw_issue2",      C_NONE,  2'd0, 2'd0, 0);
        step(f_alu(6, 5, 1),  1, 1, "redir_vs_lduse", C_FLUSH, 2'd0, 2'd0, 0);
        step(f_nop(),         0, 1, "after_redir",    C_NONE,  2'd0, 2'd0, 0);

        // sw in MEM, dmem_ready low 3 cycles; add x4 held in EX shadow across the freeze
        step(f_sw(1, 2),      0, 1, "sw_issue",       C_NONE,  2'd0, 2'd0, 0);
        step(f_alu(4, 1, 2),  0, 1, "add_x4",         C_NONE,  2'd0, 2'd0, 0);
        for (int k = 0; k < 3; k++)
            step(f_alu(7, 4, 4), 0, 0, "memwait3",    C_FREEZE, 2'd0, 2'd0, 0);
        step(f_alu(7, 4, 4),  0, 1, "memwait3_exit",  C_NONE,  2'd0, 2'd0, 0);
        step(f_nop(),         0, 1, "shadow_kept",    C_NONE,  2'd1, 2'd1, 0);

        // 65 wait cycles -> mem_err; exit together with a held redirect
        step(f_sw(1, 2),      0, 1, "sw_issue2",      C_NONE,  2'd0, 2'd0, 0);
        step(f_nop(),         0, 1, "sw_in_ex",       C_NONE,  2'd0, 2'd0, 0);
        for (int k = 0; k < 65; k++)
            step(f_nop(),     0, 0, "memwait65",      C_FREEZE, 2'd0, 2'd0, 0);
        step(f_nop(),         1, 1, "timeout_exit",   C_FLUSH, 2'd0, 2'd0, 1);
        step(f_nop(),         0, 1, "mem_err_sticky", C_NONE,  2'd0, 2'd0, 1);

        // reset in the middle of MEMWAIT
        step(f_sw(1, 2),      0, 1, "sw_issue3",      C_NONE,  2'd0, 2'd0, 1);
        step(f_nop(),         0, 1, "sw_in_ex3",      C_NONE,  2'd0, 2'd0, 1);
        step(f_nop(),         0, 0, "memwait_pre_rst", C_FREEZE, 2'd0, 2'd0, 1);
        step(f_nop(),         0, 0, "memwait_pre_rst", C_FREEZE, 2'd0, 2'd0, 1);
        do_reset(1'b0);
        step(f_nop(),         0, 0, "post_reset",     C_NONE,  2'd0, 2'd0, 0);
        step(f_alu(5, 1, 2),  0, 1, "resume_prod",    C_NONE,  2'd0, 2'd0, 0);
        step(f_alu(7, 5, 5),  0, 1, "resume_cons",    C_NONE,  2'd0, 2'd0, 0);
        step(f_nop(),         0, 1, "resume_fwd",     C_NONE,  2'd1, 2'd1, 0);

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got=%0d queued exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
